// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - multi-cycle RV32I control sequencer with shared fetch/data memory port
package risc_pkg;
  localparam int RISCV_XLEN = 32;

  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'b0000011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_AUIPC  = 7'b0010111,
    OPCODE_STORE  = 7'b0100011,
    OPCODE_OP     = 7'b0110011,
    OPCODE_LUI    = 7'b0110111,
    OPCODE_FLOATP = 7'b1010011,
    OPCODE_BRANCH = 7'b1100011,
    OPCODE_JALR   = 7'b1100111,
    OPCODE_JAL    = 7'b1101111,
    OPCODE_SYSTEM = 7'b1110011
  } op_enum_inst_opcodes;

  // ALU codes share the {funct7_5,funct3} encoding so R-type decode is a straight copy
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } op_enum_alu;

  typedef enum logic [3:0] {
    R_ADD  = 4'b0000,
    R_SLL  = 4'b0001,
    R_SLT  = 4'b0010,
    R_SLTU = 4'b0011,
    R_XOR  = 4'b0100,
    R_SRL  = 4'b0101,
    R_OR   = 4'b0110,
    R_AND  = 4'b0111,
    R_SUB  = 4'b1000,
    R_SRA  = 4'b1101
  } op_enum_r_type_funct75_funct3;

  typedef enum logic [2:0] {
    DMEM_BYTE   = 3'd0,
    DMEM_HALF   = 3'd1,
    DMEM_WORD   = 3'd2,
    DMEM_BYTE_U = 3'd4,
    DMEM_HALF_U = 3'd5
  } op_enum_dmem_size;

  typedef enum logic [1:0] {
    WR_ALU = 2'd0,
    WR_MEM = 2'd1,
    WR_IMM = 2'd2,
    WR_PC  = 2'd3
  } op_enum_wr_data_sel;
endpackage

module riscv_mc_ctrl
  import risc_pkg::*;
#(
  parameter int XLEN = RISCV_XLEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  input  logic       cmp_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic [2:0] mem_size,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic [1:0] pc_sel,
  output logic [3:0] alu_op,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] rf_wr_sel,
  output logic       illegal,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
  } state_e;

  state_e state_q, state_d;
  // run_q holds FETCH silent until the first clock edge after reset release
  logic   run_q, run_d;

  logic       is_load, is_store, is_branch, is_op, is_op_imm;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_system;
  logic       known_op, r_ok, bad_funct, dec_illegal, br_taken, xlen_ok;
  logic [3:0] r_code, dec_alu;
  logic       dec_a_sel, dec_b_sel;

  // A non-RV32 build traps every instruction rather than mis-sequencing
  assign xlen_ok = (XLEN == 32);
  assign run_d   = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    is_load   = (opcode == OPCODE_LOAD);
    is_store  = (opcode == OPCODE_STORE);
    is_branch = (opcode == OPCODE_BRANCH);
    is_op     = (opcode == OPCODE_OP);
    is_op_imm = (opcode == OPCODE_OP_IMM);
    is_lui    = (opcode == OPCODE_LUI);
    is_auipc  = (opcode == OPCODE_AUIPC);
    is_jal    = (opcode == OPCODE_JAL);
    is_jalr   = (opcode == OPCODE_JALR);
    is_system = (opcode == OPCODE_SYSTEM);
    known_op  = is_load | is_store | is_branch | is_op | is_op_imm |
                is_lui | is_auipc | is_jal | is_jalr | is_system;

    r_code = {funct7_5, funct3};
    r_ok   = !r_code[3] || (r_code == R_SUB) || (r_code == R_SRA);
    bad_funct = (is_branch && (funct3 == 3'd2 || funct3 == 3'd3))
             || (is_load && (funct3 == 3'd3 || funct3 >= 3'd6))
             || (is_store && (funct3 > 3'd2))
             || (is_op && !r_ok);
    dec_illegal = !xlen_ok || !known_op || bad_funct;

    dec_alu = ALU_ADD;
    if (is_op) begin
      dec_alu = r_code;
    end else if (is_op_imm) begin
      // funct7_5 is an immediate bit except for the SRLI/SRAI pair
      dec_alu = (funct3 == 3'd5) ? r_code : {1'b0, funct3};
    end else if (is_branch) begin
      dec_alu = ALU_SUB;
    end
    dec_a_sel = is_auipc;
    dec_b_sel = is_op_imm | is_load | is_store | is_auipc | is_jalr;

    br_taken = 1'b0;
    case (funct3)
      3'd0:    br_taken = cmp_eq;
      3'd1:    br_taken = !cmp_eq;
      3'd4:    br_taken = cmp_lt;
      3'd5:    br_taken = !cmp_lt;
      3'd6:    br_taken = cmp_ltu;
      3'd7:    br_taken = !cmp_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (run_q && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal)    state_d = S_TRAP;
        else if (is_system) state_d = S_HALT;
        else                state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_branch)               state_d = S_FETCH;
        else if (is_load || is_store) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM:    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_size     = 3'd0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_op       = 4'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    rf_wr_sel    = 2'd0;
    illegal      = 1'b0;
    halted       = 1'b0;

    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op    = dec_alu;
      alu_a_sel = dec_a_sel;
      alu_b_sel = dec_b_sel;
    end

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          mem_req  = 1'b1;
          mem_size = DMEM_WORD;
          ir_we    = mem_ready;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        mem_size     = funct3;
        mdr_we       = mem_ready && is_load;
        pc_we        = mem_ready && is_store;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (is_jal)       pc_sel = 2'd1;
        else if (is_jalr) pc_sel = 2'd2;
        if (is_lui)                 rf_wr_sel = WR_IMM;
        else if (is_load)           rf_wr_sel = WR_MEM;
        else if (is_jal || is_jalr) rf_wr_sel = WR_PC;
        else                        rf_wr_sel = WR_ALU;
      end
      S_TRAP:  illegal = 1'b1;
      S_HALT:  halted  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control sequencer for the RV32I core, for the variant where one single-port memory serves both instruction fetch and data access. It decodes opcode/funct fields into `risc_pkg` control enums and steps the datapath through FETCH/DECODE/EXEC/MEM/WB. It also arbitrates the shared memory port between fetch and load/store. It contains no datapath registers; PC, IR, MDR and the register file live in the datapath and are enabled from here.

## Interface
Parameters:
- `XLEN`, `risc_pkg::RISCV_XLEN` (32): datapath width; only checked for 32.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  7  IR[6:0], as `op_enum_inst_opcodes`.
- `funct3`  in  3  IR[14:12].
- `funct7_5`  in  1  IR[30].
- `cmp_eq`, `cmp_lt`, `cmp_ltu`  in  1 each  rs1/rs2 comparator flags (signed/unsigned).
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write (store).
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result.
- `mem_size`  out  3  `op_enum_dmem_size`; for loads, bit 2 = unsigned.
- `ir_we`, `mdr_we`, `pc_we`, `rf_we`  out  1 each  datapath register enables.
- `pc_sel`  out  2  0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],0}.
- `alu_op`  out  4  `op_enum_alu`.
- `alu_a_sel`  out  1  0 = rs1, 1 = PC.
- `alu_b_sel`  out  1  0 = rs2, 1 = imm.
- `rf_wr_sel`  out  2  `op_enum_wr_data_sel`.
- `illegal`  out  1  sticky: illegal instruction trapped.
- `halted`  out  1  sticky: ECALL/EBREAK reached.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT. Reset state is FETCH.
- FETCH:
  - Drives `mem_req`=1, `mem_addr_sel`=0, `mem_size`=WORD, `mem_we`=0.
  - Holds until `mem_ready`. In the `mem_ready` cycle, `ir_we`=1 and the next state is DECODE.
- DECODE (1 cycle):
  - Unknown opcode, `OPCODE_FLOATP`, branch funct3 2/3, load funct3 3/6/7, or store funct3 >2 → TRAP.
  - `OPCODE_SYSTEM` → HALT.
  - Otherwise → EXEC.
- `alu_op` decode:
  - R-type: {funct7_5,funct3} maps per `op_enum_r_type_funct75_funct3`. Codes other than ADD..AND/SUB/SRA → TRAP in DECODE.
  - I-ALU: funct3 maps the same way; funct7_5 is used only when funct3=5 (SRAI). ADDI never yields SUB.
  - LOAD/STORE/AUIPC/JAL/JALR: ADD. Branch: SUB (result unused).
- Operand selects:
  - `alu_a_sel`=1 only for AUIPC.
  - `alu_b_sel`=1 for I-ALU, LOAD, STORE, AUIPC, JALR.
- EXEC (1 cycle):
  - Branch: `pc_we`=1. `pc_sel`=1 if the condition holds (BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu), else 0. Next state FETCH.
  - LOAD/STORE → MEM. All others → WB.
- MEM:
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=store, `mem_size`=funct3.
  - Holds until `mem_ready`.
  - Load: `mdr_we`=1 → WB.
  - Store: `pc_we`=1, `pc_sel`=0 → FETCH.
- WB (1 cycle): `rf_we`=1, `pc_we`=1, then FETCH. `rf_wr_sel` and `pc_sel` per opcode:
  - R/I-ALU/AUIPC: ALU / 0.
  - LUI: IMM / 0.
  - LOAD: MEM / 0.
  - JAL: PC / 1.
  - JALR: PC / 2.
- TRAP and HALT are terminal until reset. `illegal` / `halted` = 1 there, and all enables = 0.

## Timing
- Every output is 0 in reset, in TRAP and in HALT; `mem_size`=0.
- Outputs are Moore on state plus IR fields. Exceptions: `ir_we`, `mdr_we`, the MEM-state `pc_we`, and all state transitions out of FETCH and MEM, which are qualified by `mem_ready`.
- `mem_req`, `mem_we`, `mem_size` and `mem_addr_sel` stay constant while waiting. `mem_req` never drops before `mem_ready`.
- Back-to-back FETCH→MEM access is impossible; the port is never requested twice in one cycle.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - Branch: 3 cycles.
  - R/I/U/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each memory wait cycle adds 1.
- `mem_ready` outside FETCH/MEM is ignored.
- `rst_n` low mid-operation forces FETCH and zeros all outputs immediately (asynchronous), including a pending `mem_req`. The first fetch starts on the first clock edge after release.

## Test plan
- R-type ADD `0x002081B3`, `mem_ready`=1 → states F,D,E,W. In W: `alu_op`=ADD, `rf_we`=1, `rf_wr_sel`=ALU, `pc_we`=1, `pc_sel`=0. Then F again.
- LW `0x0000A183` with `mem_ready` low for 2 cycles in MEM → `mem_req` held 3 cycles with `mem_size`=WORD and `mem_addr_sel`=1. `mdr_we` fires in the ready cycle; then WB with `rf_wr_sel`=MEM. Total 7 cycles.
- BNE, `cmp_eq`=0 → EXEC `pc_sel`=1. Same instruction with `cmp_eq`=1 → `pc_sel`=0. Both take 3 cycles with no `rf_we`.
- JALR `0x000080E7` → WB: `rf_wr_sel`=PC, `pc_sel`=2, `alu_b_sel`=1.
- Opcode `0x0000007F`, then ECALL `0x00000073` after reset → `illegal`=1 and stuck (no `mem_req`), then `halted`=1 and stuck.
- `rst_n` asserted during a MEM wait → `mem_req` drops in the same cycle. After release, the next request has `mem_addr_sel`=0.
